jts16_gfx_arb: RTL and testbench
================================

// Module: jts16_gfx_arb
// PURPOSE
//  Shares one SDRAM read port between the tile/sprite fetchers of the video subsystem
//  (char, map1, scr1, map2, scr2, obj). Each requester has a one-entry tag/data buffer.
//  A hit is served with no SDRAM access. Misses are granted round-robin, one transaction
//  at a time. Sits between the layer fetchers and the SDRAM controller.
// PARAMETERS
//  N   6   number of requesters (bit i of every vector = requester i; 0=char..5=obj)
//  AW  22  SDRAM word address width (requesters present full address, base already added)
//  DW  32  data width
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      synchronous reset, active low
//  downloading in   1      ROM load in progress: blocks new grants, invalidates buffers
//  req         in   N      requester i wants data at addr[i]
//  addr        in   N*AW   packed addresses, requester i at [i*AW +: AW]
//  ok          out  N      data[i] valid for current addr[i]
//  data        out  N*DW   packed per-requester data, [i*DW +: DW]
//  sdram_req   out  1      read request to SDRAM controller
//  sdram_addr  out  AW     read address
//  sdram_ack   in   1      controller accepted request
//  sdram_rdy   in   1      sdram_din valid (one cycle)
//  sdram_din   in   DW     read data
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, rr=0, all valid[i]=0, tag/data regs=0.
//   - sdram_req=0, sdram_addr=0, ok=0, data=0.
//  Hit: ok[i] = req[i] & valid[i] & (addr[i]==tag[i]); combinational from registered tag/valid.
//   - data[i] = data_reg[i], always driven, even when ok[i]=0.
//  miss[i] = req[i] & ~ok[i] & ~downloading.
//  FSM:
//   - IDLE: if any miss, grant g = first set miss bit scanning rr, rr+1 .. N-1, 0 .. rr-1.
//     Latch g and addr[g] into sdram_addr; sdram_req<=1; go WAIT_ACK. Else stay.
//   - WAIT_ACK: hold sdram_req/sdram_addr until sdram_ack.
//     On ack: sdram_req<=0; go WAIT_RDY.
//     If sdram_rdy is asserted in the same cycle as ack, treat it as ack+rdy and complete
//     directly (see WAIT_RDY).
//   - WAIT_RDY: on sdram_rdy: tag[g]<=sdram_addr, data_reg[g]<=sdram_din, valid[g]<=1,
//     rr<=(g==N-1)?0:g+1; go IDLE.
//  Latency: miss seen at edge k -> sdram_req high after edge k.
//   - ok[g] high the cycle after the rdy edge.
//   - At least one IDLE cycle between transactions.
//  Boundary conditions:
//   - Requester changes addr mid-transaction: the fill still completes with the latched
//     address; ok stays 0 (tag mismatch); the new address misses again later.
//   - Requester drops req mid-transaction: the transaction completes and the buffer is filled.
//   - downloading=1: valid[] cleared every cycle; no new grant from IDLE; ok=0.
//     An in-flight transaction runs to completion but its fill is discarded (valid stays 0).
//   - sdram_rdy/ack while IDLE: ignored. This covers stale responses after reset mid-transfer.
//   - rr wraps N-1 -> 0. A single persistent requester may be granted back to back.
//   - Address 0 is a legal address: hit requires valid, not a non-zero tag.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with req=6'h3F -> sdram_req=0, ok=0, data=0.
//    After release: first grant goes to requester 0.
//  2 Fill then hit: req[2]=1, addr[2]=22'h01234; ack 3 cycles later, rdy with 32'hDEADBEEF
//    after 5 more cycles -> ok[2]=1, data[2]=DEADBEEF.
//    Re-request the same address -> no new sdram_req.
//  3 Fairness: all 6 requesters miss continuously with distinct addresses -> grant order
//    0,1,2,3,4,5,0.
//    With only requesters 1 and 4 missing after a grant to 4 -> next grant is 1.
//  4 Address change mid-flight: requester 5 changes 22'h00100 -> 22'h00200 during WAIT_RDY
//    -> fill tagged 22'h00100, ok[5]=0, then a new request issues for 22'h00200.
//  5 Same-cycle ack+rdy -> completes directly.
//    Stray rdy in IDLE -> no buffer change, no ok pulse.
//  6 downloading=1 mid-transaction -> all ok drop next cycle; in-flight fill not marked valid;
//    no sdram_req while high.
//    After downloading=0: prior addresses re-fetched.

Source files
------------

// File: rtl/jts16_gfx_arb.sv
// jts16_gfx_arb
// Arbitrates one SDRAM read port between the video layer fetchers.
// Each requester owns a single-entry tag/data buffer: hits are answered
// combinationally from it, misses are queued round-robin one at a time.

module jts16_gfx_arb #(
  parameter int N  = 6,
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] addr,
  output logic [N-1:0]    ok,
  output logic [N*DW-1:0] data,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            sdram_rdy,
  input  logic [DW-1:0]   sdram_din
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [GW-1:0] LAST = GW'(N - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] WAIT_RDY = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] rr;
  logic [GW-1:0] gnt;
  logic [N-1:0]  valid;
  logic [AW-1:0] tag  [N];
  logic [DW-1:0] dreg [N];
  logic [AW-1:0] addr_arr [N];

  logic [N-1:0]  miss;
  logic          found;
  logic [GW-1:0] pick;
  logic [GW:0]   sum;
  logic [GW-1:0] idx;
  logic          fill;

  // Unpack per-requester address lanes and expose the buffered data
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign addr_arr[i]         = addr[i*AW +: AW];
    assign data[i*DW +: DW]    = dreg[i];
  end

  // Hit detection straight from the registered tag/valid; a miss only counts outside ROM download
  always_comb begin
    ok   = '0;
    miss = '0;
    for (int i = 0; i < N; i++) begin
      ok[i]   = req[i] & valid[i] & (addr_arr[i] == tag[i]);
      miss[i] = req[i] & ~ok[i] & ~downloading;
    end
  end

  // Round-robin pick: first missing requester scanning upward from rr, wrapping at N
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr} + (GW+1)'(k);
      if (sum >= (GW+1)'(N)) sum = sum - (GW+1)'(N);
      idx = sum[GW-1:0];
      if (!found && miss[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // A transaction completes on rdy in WAIT_RDY, or on ack and rdy together in WAIT_ACK
  always_comb begin
    fill = 1'b0;
    if (state == WAIT_ACK && sdram_ack && sdram_rdy) fill = 1'b1;
    if (state == WAIT_RDY && sdram_rdy)              fill = 1'b1;
  end

  // Transaction sequencer: grant, hold the request until ack, wait for the data beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= '0;
      gnt        <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt        <= pick;
            sdram_addr <= addr_arr[pick];
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= sdram_rdy ? IDLE : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (sdram_rdy) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          sdram_req <= 1'b0;
        end
      endcase
      if (fill) rr <= (gnt == LAST) ? '0 : gnt + 1'b1;
    end
  end

  // Buffer update: downloads wipe every entry and swallow any fill that lands meanwhile
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < N; i++) begin
        tag[i]  <= '0;
        dreg[i] <= '0;
      end
    end else if (downloading) begin
      valid <= '0;
    end else if (fill) begin
      tag[gnt]   <= sdram_addr;
      dreg[gnt]  <= sdram_din;
      valid[gnt] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jts16_gfx_arb.sv
// tb_jts16_gfx_arb
// Table of fill/hit vectors plus directed sequences for reset, fairness,
// mid-flight address change, stray responses and ROM download.
// Expected SDRAM addresses go into a queue and are popped on each new request.

module tb_jts16_gfx_arb;

  localparam int N  = 6;
  localparam int AW = 22;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            downloading;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    ok;
  logic [N*DW-1:0] data;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            sdram_rdy;
  logic [DW-1:0]   sdram_din;

  int compared   = 0;
  int mismatched = 0;

  logic [AW-1:0] exp_q [$];
  logic [DW-1:0] exp_data [N];
  logic          prev_req = 1'b0;

  typedef struct {
    int            r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            ack_dly;
    int            rdy_dly;
    bit            fetch;
  } vec_t;

  vec_t vecs [7];

  jts16_gfx_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .req         (req),
    .addr        (addr),
    .ok          (ok),
    .data        (data),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .sdram_rdy   (sdram_rdy),
    .sdram_din   (sdram_din)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_data_all(input string name);
    for (int i = 0; i < N; i++)
      check_output(name, 64'(data[i*DW +: DW]), 64'(exp_data[i]));
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  // Scoreboard: every rising sdram_req must match the oldest expected address
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sdram_req === 1'b1 && prev_req === 1'b0) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_req: got sdram_addr %h, expected no request", sdram_addr);
      end else begin
        check_output("grant_addr", 64'(sdram_addr), 64'(exp_q.pop_front()));
      end
    end
    prev_req = sdram_req;
  end

  // Waits for a request, acks it after ack_dly cycles, optionally with rdy in the same cycle
  task automatic serve_ack(input int ack_dly, input bit same_rdy, input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sdram_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL req_timeout: got sdram_req 0 for 40 cycles, expected 1");
      return;
    end
    repeat (ack_dly) @(negedge clk);
    check_output("req_held", 64'(sdram_req), 64'd1);
    sdram_ack = 1'b1;
    if (same_rdy) begin
      sdram_rdy = 1'b1;
      sdram_din = d;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    check_output("req_drop", 64'(sdram_req), 64'd0);
  endtask

  task automatic serve_rdy(input int rdy_dly, input logic [DW-1:0] d);
    repeat (rdy_dly - 1) @(negedge clk);
    sdram_rdy = 1'b1;
    sdram_din = d;
    @(negedge clk);
    sdram_rdy = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    req = onehot(v.r);
    set_addr(v.r, v.a);
    #1;
    check_output("vec_pre_ok", 64'(ok), v.fetch ? 64'd0 : 64'(onehot(v.r)));
    if (v.fetch) begin
      exp_q.push_back(v.a);
      serve_ack(v.ack_dly, v.rdy_dly == 0, v.d);
      if (v.rdy_dly != 0) serve_rdy(v.rdy_dly, v.d);
      exp_data[v.r] = v.d;
    end else begin
      repeat (3) @(negedge clk);
    end
    #1;
    check_output("vec_ok", 64'(ok), 64'(onehot(v.r)));
    check_data_all("vec_data");
  endtask

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{2, 22'h001234, 32'hDEADBEEF, 3, 5, 1'b1};
    vecs[1] = '{2, 22'h001234, 32'h0,        0, 0, 1'b0};
    vecs[2] = '{3, 22'h000000, 32'hCAFEF00D, 1, 2, 1'b1};
    vecs[3] = '{3, 22'h000000, 32'h0,        0, 0, 1'b0};
    vecs[4] = '{1, 22'h3FFFFF, 32'h0BADC0DE, 2, 0, 1'b1};
    vecs[5] = '{2, 22'h001235, 32'h12345678, 0, 1, 1'b1};
    vecs[6] = '{2, 22'h001234, 32'hA5A5A5A5, 1, 1, 1'b1};

    // Reset with every requester asserted
    rst_n       = 1'b0;
    downloading = 1'b0;
    req         = '1;
    sdram_ack   = 1'b0;
    sdram_rdy   = 1'b0;
    sdram_din   = '0;
    addr        = '0;
    for (int i = 0; i < N; i++) begin
      set_addr(i, 22'h000AA0 + AW'(i));
      exp_data[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_output("rst_sdram_req", 64'(sdram_req), 64'd0);
    check_output("rst_ok", 64'(ok), 64'd0);
    check_data_all("rst_data");

    // First grant after release goes to requester 0
    rst_n = 1'b1;
    exp_q.push_back(22'h000AA0);
    serve_ack(1, 1'b0, '0);
    serve_rdy(1, 32'h11110000);
    exp_data[0] = 32'h11110000;
    #1;
    check_output("first_grant_ok", 64'(ok), 64'(onehot(0)));
    check_data_all("first_grant_data");
    req = '0;

    // Table-driven fill/hit vectors
    for (int v = 0; v < 7; v++) apply_stimulus(vecs[v]);

    // Stray rdy while idle leaves buffers untouched
    req = '0;
    @(negedge clk);
    sdram_rdy = 1'b1;
    sdram_din = '1;
    @(negedge clk);
    sdram_rdy = 1'b0;
    #1;
    check_output("stray_ok", 64'(ok), 64'd0);
    check_data_all("stray_data");
    req = onehot(2);
    set_addr(2, 22'h001234);
    #1;
    check_output("stray_hit", 64'(ok), 64'(onehot(2)));

    // Fairness: fresh reset so rr starts at 0, all six miss
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_data[i] = '0;
      set_addr(i, 22'h001000 + AW'(i));
      exp_q.push_back(22'h001000 + AW'(i));
    end
    exp_q.push_back(22'h002000);
    req = '1;
    for (int k = 0; k < N; k++) begin
      serve_ack(1, 1'b0, '0);
      serve_rdy(1, 32'hF0000000 + DW'(k));
      exp_data[k] = 32'hF0000000 + DW'(k);
      #1;
      if (k == 0) set_addr(0, 22'h002000);
    end
    serve_ack(0, 1'b0, '0);
    serve_rdy(2, 32'h0BEEF000);
    exp_data[0] = 32'h0BEEF000;
    #1;
    check_output("fair_all_ok", 64'(ok), 64'h3F);
    check_data_all("fair_data");

    // Grant to 4, then 1 and 4 both miss: 1 must come next
    req = onehot(4);
    set_addr(4, 22'h003004);
    exp_q.push_back(22'h003004);
    serve_ack(1, 1'b0, '0);
    serve_rdy(1, 32'h44440000);
    exp_data[4] = 32'h44440000;
    #1;
    req = onehot(1) | onehot(4);
    set_addr(1, 22'h003001);
    set_addr(4, 22'h003014);
    exp_q.push_back(22'h003001);
    exp_q.push_back(22'h003014);
    serve_ack(1, 1'b0, '0);
    serve_rdy(1, 32'h11112222);
    exp_data[1] = 32'h11112222;
    serve_ack(1, 1'b0, '0);
    serve_rdy(1, 32'h44445555);
    exp_data[4] = 32'h44445555;
    #1;
    check_output("rr_skip_ok", 64'(ok), 64'(onehot(1) | onehot(4)));

    // Requester 5 moves its address while the fill is outstanding
    req = onehot(5);
    set_addr(5, 22'h000100);
    exp_q.push_back(22'h000100);
    serve_ack(1, 1'b0, '0);
    @(negedge clk);
    set_addr(5, 22'h000200);
    exp_q.push_back(22'h000200);
    serve_rdy(2, 32'h55551111);
    exp_data[5] = 32'h55551111;
    #1;
    check_output("addr_change_ok", 64'(ok), 64'd0);
    check_data_all("addr_change_data");
    serve_ack(1, 1'b0, '0);
    serve_rdy(1, 32'h55552222);
    exp_data[5] = 32'h55552222;
    #1;
    check_output("addr_refetch_ok", 64'(ok), 64'(onehot(5)));

    // ROM download during an outstanding fill
    req = onehot(2) | onehot(3);
    set_addr(2, 22'h001002);
    set_addr(3, 22'h004003);
    #1;
    check_output("dl_pre_ok", 64'(ok), 64'(onehot(2)));
    exp_q.push_back(22'h004003);
    serve_ack(1, 1'b0, '0);
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
    #1;
    check_output("dl_ok_drop", 64'(ok), 64'd0);
    serve_rdy(1, 32'h66660000);
    #1;
    check_output("dl_fill_ok", 64'(ok), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    check_output("dl_hold_ok", 64'(ok), 64'd0);
    check_output("dl_no_req", 64'(sdram_req), 64'd0);
    exp_q.push_back(22'h001002);
    exp_q.push_back(22'h004003);
    downloading = 1'b0;
    serve_ack(1, 1'b0, '0);
    serve_rdy(1, 32'h77770002);
    exp_data[2] = 32'h77770002;
    serve_ack(1, 1'b0, '0);
    serve_rdy(1, 32'h77770003);
    exp_data[3] = 32'h77770003;
    #1;
    check_output("dl_refetch_ok", 64'(ok), 64'(onehot(2) | onehot(3)));
    check_data_all("dl_refetch_data");

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
